// File: rtl/run_detect_if.sv
// run_detect_if: bundles the serial stimulus/control inputs and the
// observable outputs of run_detect_fsm.
//   x, en, clear          : stimulus/control (driven by master)
//   state, run_len,
//   hit_count, z_run,
//   z_end                 : detector outputs (driven by slave)
interface run_detect_if #(
   parameter int unsigned CNT_W = 8
);
   logic             x;
   logic             en;
   logic             clear;
   logic [2:0]       state;
   logic [CNT_W-1:0] run_len;
   logic [CNT_W-1:0] hit_count;
   logic             z_run;
   logic             z_end;

   modport master (
      output x, en, clear,
      input  state, run_len, hit_count, z_run, z_end
   );

   modport slave (
      input  x, en, clear,
      output state, run_len, hit_count, z_run, z_end
   );
endinterface

// File: rtl/run_detect_fsm.sv
// run_detect_fsm: detects runs of consecutive 1s on serial input x.
//   clk       : system clock, all state updates on posedge
//   reset     : synchronous active-high reset (overrides en and clear)
//   bus.x     : serial input bit
//   bus.en    : advance enable; 0 holds state and suppresses z outputs
//   bus.clear : synchronous clear of hit_count (acts regardless of en)
//   bus.state : one-hot state IDLE=001, COUNT=010, HIT=100
//   bus.run_len   : length of current run of 1s, saturating
//   bus.hit_count : completed HIT runs, wrapping
//   bus.z_run : Mealy, run continuing past threshold
//   bus.z_end : Mealy, qualifying run ending
module run_detect_fsm #(
   parameter int unsigned RUN_LEN = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic          clk,
   input  logic          reset,
   run_detect_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      COUNT = 3'b010,
      HIT   = 3'b100
   } state_t;

   localparam logic [CNT_W-1:0] LEN_MAX = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RUN_TGT = CNT_W'(RUN_LEN);

   state_t           cur_state, nxt_state;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] hits_q, hits_d;
   logic             z_run_c, z_end_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= IDLE;
         len_q     <= '0;
         hits_q    <= '0;
      end else begin
         cur_state <= nxt_state;
         len_q     <= len_d;
         hits_q    <= hits_d;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      len_d     = len_q;
      hits_d    = hits_q;
      z_run_c   = 1'b0;
      z_end_c   = 1'b0;

      case (cur_state)
         IDLE: begin
            if (bus.en) begin
               if (bus.x) begin
                  nxt_state = COUNT;
                  len_d     = ONE;
               end else begin
                  len_d     = '0;
               end
            end
         end
         COUNT: begin
            if (bus.en) begin
               if (bus.x) begin
                  len_d = len_q + ONE;
                  if (len_d == RUN_TGT) nxt_state = HIT;
               end else begin
                  nxt_state = IDLE;
                  len_d     = '0;
               end
            end
         end
         HIT: begin
            if (bus.en) begin
               if (bus.x) begin
                  z_run_c = 1'b1;
                  if (len_q != LEN_MAX) len_d = len_q + ONE;
               end else begin
                  z_end_c   = 1'b1;
                  nxt_state = IDLE;
                  len_d     = '0;
                  hits_d    = hits_q + ONE;
               end
            end
         end
         default: begin
            // unreachable encodings recover to IDLE even while stalled
            nxt_state = IDLE;
            len_d     = '0;
         end
      endcase

      // clear beats a same-cycle increment
      if (bus.clear) hits_d = '0;

      // a run cut short by reset never reports its end
      if (reset) begin
         z_run_c = 1'b0;
         z_end_c = 1'b0;
      end
   end

   assign bus.state     = cur_state;
   assign bus.run_len   = len_q;
   assign bus.hit_count = hits_q;
   assign bus.z_run     = z_run_c;
   assign bus.z_end     = z_end_c;

endmodule

// File: tb/tb_run_detect_fsm.sv
// tb_run_detect_fsm: drives three detector instances (RUN_LEN=2/CNT_W=8,
// RUN_LEN=4/CNT_W=8, RUN_LEN=2/CNT_W=3) with a shared stimulus and checks
// every output against a behavioural model through a scoreboard queue.
module tb_run_detect_fsm;

   logic clk;
   logic rst;

   run_detect_if #(.CNT_W(8)) ia ();
   run_detect_if #(.CNT_W(8)) ib ();
   run_detect_if #(.CNT_W(3)) ic ();

   run_detect_fsm #(.RUN_LEN(2), .CNT_W(8)) u_a (.clk(clk), .reset(rst), .bus(ia));
   run_detect_fsm #(.RUN_LEN(4), .CNT_W(8)) u_b (.clk(clk), .reset(rst), .bus(ib));
   run_detect_fsm #(.RUN_LEN(2), .CNT_W(3)) u_c (.clk(clk), .reset(rst), .bus(ic));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int dut;
      int kind;
      int exp;
   } sb_t;

   sb_t sbq[$];
   int  n_chk  = 0;
   int  n_fail = 0;

   // model parameters and state per instance; state 0=IDLE 1=COUNT 2=HIT
   int rl_p[3]  = '{2, 4, 2};
   int max_p[3] = '{255, 255, 7};
   int m_st[3];
   int m_len[3];
   int m_hit[3];

   function automatic string kname(input int k);
      case (k)
         0: return "z_run";
         1: return "z_end";
         2: return "state";
         3: return "run_len";
         default: return "hit_count";
      endcase
   endfunction

   function automatic int obs(input int d, input int k);
      logic [2:0] s;
      int l, h, zr, ze;
      case (d)
         0: begin s = ia.state; l = int'(ia.run_len); h = int'(ia.hit_count); zr = int'(ia.z_run); ze = int'(ia.z_end); end
         1: begin s = ib.state; l = int'(ib.run_len); h = int'(ib.hit_count); zr = int'(ib.z_run); ze = int'(ib.z_end); end
         default: begin s = ic.state; l = int'(ic.run_len); h = int'(ic.hit_count); zr = int'(ic.z_run); ze = int'(ic.z_end); end
      endcase
      case (k)
         0: return zr;
         1: return ze;
         2: return int'(s);
         3: return l;
         default: return h;
      endcase
   endfunction

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic drain();
      sb_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         check_eq($sformatf("dut%0d_%s", e.dut, kname(e.kind)), obs(e.dut, e.kind), e.exp);
      end
   endtask

   // one clock of stimulus, entered and left at negedge
   task automatic step(input logic xi, input logic ei, input logic ci, input logic ri);
      ia.x = xi; ia.en = ei; ia.clear = ci;
      ib.x = xi; ib.en = ei; ib.clear = ci;
      ic.x = xi; ic.en = ei; ic.clear = ci;
      rst  = ri;
      for (int i = 0; i < 3; i++) begin
         sbq.push_back('{i, 0, (m_st[i] == 2 && xi && ei && !ri) ? 1 : 0});
         sbq.push_back('{i, 1, (m_st[i] == 2 && !xi && ei && !ri) ? 1 : 0});
      end
      #1;
      drain();
      for (int i = 0; i < 3; i++) begin
         if (ri) begin
            m_st[i] = 0; m_len[i] = 0; m_hit[i] = 0;
         end else begin
            if (ei) begin
               if (!xi) begin
                  if (m_st[i] == 2) m_hit[i] = (m_hit[i] + 1) % (max_p[i] + 1);
                  m_st[i]  = 0;
                  m_len[i] = 0;
               end else begin
                  if (m_len[i] < max_p[i]) m_len[i]++;
                  if (m_len[i] >= rl_p[i]) m_st[i] = 2;
                  else                     m_st[i] = 1;
               end
            end
            if (ci) m_hit[i] = 0;
         end
         sbq.push_back('{i, 2, 1 << m_st[i]});
         sbq.push_back('{i, 3, m_len[i]});
         sbq.push_back('{i, 4, m_hit[i]});
      end
      @(posedge clk);
      #1;
      drain();
      @(negedge clk);
   endtask

   task automatic ones(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic zero();
      step(1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      logic [7:0] pat;
      rst = 1'b1;
      ia.x = 1'b0; ia.en = 1'b0; ia.clear = 1'b0;
      ib.x = 1'b0; ib.en = 1'b0; ib.clear = 1'b0;
      ic.x = 1'b0; ic.en = 1'b0; ic.clear = 1'b0;
      for (int i = 0; i < 3; i++) begin
         m_st[i] = 0; m_len[i] = 0; m_hit[i] = 0;
      end
      @(negedge clk);

      // reset state
      do_reset();

      // basic pattern 0,1,0,1,1,1,0,1
      pat = 8'b1011_1010;
      for (int k = 0; k < 8; k++) step(pat[k], 1'b1, 1'b0, 1'b0);

      // short run then qualifying run (RUN_LEN=4 instance)
      do_reset();
      ones(3); zero();
      ones(5); zero();

      // saturation on the 3-bit instance
      do_reset();
      ones(10); zero();

      // stall while in HIT with x toggling, then end the run
      do_reset();
      ones(4);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      zero();

      // accumulate five hits, then clear coincident with run end
      do_reset();
      for (int r = 0; r < 5; r++) begin
         ones(5); zero();
      end
      ones(5);
      step(1'b0, 1'b1, 1'b1, 1'b0);

      // clear while stalled
      ones(5); zero();
      step(1'b1, 1'b0, 1'b1, 1'b0);
      zero();

      // reset mid-run with x=0 abandons the run
      do_reset();
      ones(3);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      zero();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/run_detect_fsm.md
# run_detect_fsm

Parametrised Moore/Mealy run detector on a single serial bit stream. It flags when a run of consecutive 1s reaches a programmable length and keeps flagging while the run continues. It flags the cycle the run ends and counts completed runs. It is the general successor to the course's fixed three-state sequence detectors, and it adds a stall enable, a run-length readout, a saturating length counter and a clearable completed-run counter.

## Interface
- RUN_LEN, 2: number of consecutive 1s that moves the FSM into HIT; legal range 2 .. 2^CNT_W-1
- CNT_W, 8: width of run_len and hit_count
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- x  in  1  serial input bit, sampled on posedge clk
- en  in  1  advance enable; 0 = hold all state, suppress z outputs
- clear  in  1  synchronous clear of hit_count only
- state  out  3  one-hot current state: IDLE=3'b001, COUNT=3'b010, HIT=3'b100
- run_len  out  CNT_W  registered length of the current run of 1s; saturates at 2^CNT_W-1
- hit_count  out  CNT_W  registered count of completed HIT runs; wraps modulo 2^CNT_W
- z_run  out  1  Mealy output: run continuing past threshold
- z_end  out  1  Mealy output: qualifying run ending

## Operation
- States:
  - IDLE: last sampled bit was 0, or post-reset.
  - COUNT: 1 .. RUN_LEN-1 consecutive 1s have been seen.
  - HIT: RUN_LEN or more consecutive 1s have been seen.
- Transitions, applied at posedge when en=1 and reset=0:
  - IDLE, x=0: stay; run_len=0.
  - IDLE, x=1: go to COUNT; run_len=1.
  - COUNT, x=0: go to IDLE; run_len=0; hit_count unchanged.
  - COUNT, x=1: run_len+1. Go to HIT if run_len+1 == RUN_LEN, else stay in COUNT.
  - HIT, x=1: stay; run_len+1, saturating at 2^CNT_W-1 (never wraps).
  - HIT, x=0: go to IDLE; run_len=0; hit_count+1, wrapping.
- Mealy outputs (combinational from state, x, en, reset):
  - z_run = HIT & x & en & ~reset.
  - z_end = HIT & ~x & en & ~reset.
  - z_run and z_end are never high together. Both are 0 in IDLE and COUNT.
- en=0: state, run_len and hit_count hold; z_run=z_end=0. clear still acts when en=0.
- clear=1: hit_count←0 next edge. If an increment is due in the same cycle, clear wins and hit_count=0.
- reset=1: state←IDLE, run_len←0, hit_count←0. Reset overrides en and clear.
- Reset during a run abandons the run: no z_end, no hit_count increment.
- Illegal state encodings, which cannot be reached: next state is IDLE.

## Timing
- Reset values: state=3'b001, run_len=0, hit_count=0, z_run=0, z_end=0.
- Latency:
  - z_run and z_end have zero latency, combinational in the same cycle as x.
  - state, run_len and hit_count update one edge after x is sampled.
- The first assertion of z_run is on the (RUN_LEN+1)-th consecutive 1. The RUN_LEN-th 1 only enters HIT.
- z_end asserts in the cycle x=0 is presented while in HIT. hit_count reflects that run on the following cycle.
- x must be stable around posedge clk. Outputs are glitch-free only if x is synchronous to clk.

## Test plan
- RUN_LEN=2, reset then x=0,1,0,1,1,1,0,1:
  - state sequence IDLE,IDLE,COUNT,IDLE,COUNT,HIT,HIT,IDLE,COUNT.
  - z_run high only on the 3rd consecutive 1.
  - z_end high on the following 0.
  - hit_count=1 at end.
- RUN_LEN=4, x=1,1,1,0 then 1,1,1,1,1,0:
  - first run: no z_end, hit_count stays 0.
  - second run: HIT after the 4th 1, z_run on the 5th, z_end on the 0, hit_count=1.
  - run_len peaks at 5.
- CNT_W=3, RUN_LEN=2, x=1 for 10 cycles:
  - run_len saturates at 7 and holds.
  - z_run stays high from the 3rd 1 onward.
  - then x=0: z_end=1, run_len=0, hit_count=1.
- In HIT with x=1, drive en=0 for 3 cycles with x toggling:
  - z_run=z_end=0, state/run_len/hit_count frozen.
  - restore en=1, x=0: z_end=1.
- hit_count=5, drive clear=1 in the same cycle as z_end=1: next cycle hit_count=0.
- In HIT with run_len=3, assert reset for 1 cycle with x=0:
  - z_end=0 during reset.
  - next cycle state=IDLE, run_len=0, hit_count=0.
